// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: turns a speed level and a direction code into ramped PWM
// enables and H-bridge pins for the left and right drive motors.
// A bridge polarity change always ramps the duty to zero and then holds a
// dead-time interval before the new polarity is applied.
// Build option: define MOTOR_SOFT_RAMP_EN for slewed duty; when undefined the
// duty jumps straight to its goal and the ramp timer is not built.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// STOP      | bridge coasting, duty 0, waiting for a move code
// RUN       | bridge wired for active_dir, duty follows the speed target
// RAMP_DOWN | direction changed, duty heading to 0 before the bridge flips
// DEAD      | duty 0, bridge coasting, dead-time counter running
module motor_pwm_driver #(
    parameter int PWM_DIV     = 10,
    parameter int RAMP_DIV    = 50000,
    parameter int RAMP_STEP   = 4,
    parameter int DEAD_CYCLES = 5000,
    parameter int LEVEL_SCALE = 32
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [2:0] direction,
    input  logic [2:0] speed,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic [1:0] in_left,
    output logic [1:0] in_right,
    output logic [7:0] duty,
    output logic       busy
);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [1:0] {STOP, RUN, RAMP_DOWN, DEAD} state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      active_dir;
    logic [DW-1:0]   dead_cnt;
    logic [PW-1:0]   pwm_div_cnt;
    logic [7:0]      pwm_cnt;
    logic            dir_move;
    logic [10:0]     scaled;
    logic [7:0]      target;
    logic [7:0]      goal;

    // Pin pattern {left, right} for a direction code; stop codes coast.
    function automatic logic [3:0] bridge_pins(input logic [2:0] dir);
        case (dir)
            3'b001:  return 4'b10_10;
            3'b011:  return 4'b01_01;
            3'b010:  return 4'b01_10;
            3'b100:  return 4'b10_01;
            default: return 4'b00_00;
        endcase
    endfunction

    // Speed target, saturated to the 8-bit duty range; zero for stop codes.
    always_comb begin
        dir_move = (direction == 3'b001) || (direction == 3'b011) ||
                   (direction == 3'b010) || (direction == 3'b100);
        scaled   = 11'(speed) * 11'(LEVEL_SCALE);
        target   = 8'd0;
        if (dir_move)
            target = (scaled > 11'd255) ? 8'hFF : scaled[7:0];
    end

    // Next state; the duty goal follows the state being entered so a ramp tick
    // coinciding with a transition already heads for the new goal.
    always_comb begin
        next_state = state;
        case (state)
            STOP:      if (dir_move) next_state = RUN;
            RUN:       if (direction != active_dir) next_state = RAMP_DOWN;
            RAMP_DOWN: begin
                if (direction == active_dir) next_state = RUN;
                else if (duty == 8'd0)       next_state = DEAD;
            end
            DEAD:      if (dead_cnt == '0) next_state = dir_move ? RUN : STOP;
            default:   next_state = STOP;
        endcase
        goal = (next_state == RUN) ? target : 8'd0;
    end

    // State register, latched direction, dead-time counter and bridge outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STOP;
            active_dir <= 3'b000;
            dead_cnt   <= '0;
            in_left    <= 2'b00;
            in_right   <= 2'b00;
            busy       <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == STOP || state == DEAD) && next_state == RUN)
                active_dir <= direction;
            if (state == RAMP_DOWN && next_state == DEAD)
                dead_cnt <= DW'(DEAD_CYCLES - 1);
            else if (state == DEAD && dead_cnt != '0)
                dead_cnt <= dead_cnt - 1'b1;
            if (state == RUN || state == RAMP_DOWN)
                {in_left, in_right} <= bridge_pins(active_dir);
            else
                {in_left, in_right} <= 4'b00_00;
            busy <= (state == RAMP_DOWN) || (state == DEAD);
        end
    end

`ifdef MOTOR_SOFT_RAMP_EN
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RW-1:0] ramp_cnt;
    logic          ramp_tick;
    logic [8:0]    gap_up;
    logic [8:0]    gap_down;

    assign ramp_tick = (ramp_cnt == RW'(RAMP_DIV - 1));
    assign gap_up    = {1'b0, goal} - {1'b0, duty};
    assign gap_down  = {1'b0, duty} - {1'b0, goal};

    // Free-running ramp timer, not aligned to direction changes.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)         ramp_cnt <= '0;
        else if (ramp_tick) ramp_cnt <= '0;
        else                ramp_cnt <= ramp_cnt + 1'b1;
    end

    // Slew duty toward the goal by one step per tick without overshooting.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            duty <= 8'd0;
        end else if (ramp_tick) begin
            if (duty < goal)
                duty <= (gap_up > 9'(RAMP_STEP)) ? duty + 8'(RAMP_STEP) : goal;
            else if (duty > goal)
                duty <= (gap_down > 9'(RAMP_STEP)) ? duty - 8'(RAMP_STEP) : goal;
        end
    end
`else
    logic [31:0] ramp_cfg_unused;
    assign ramp_cfg_unused = 32'(RAMP_DIV) ^ 32'(RAMP_STEP);

    // Without slewing the duty takes its goal on the next cycle.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) duty <= 8'd0;
        else        duty <= goal;
    end
`endif

    // PWM counter prescaler and registered comparators, gated by a coasting bridge.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_div_cnt <= '0;
            pwm_cnt     <= 8'd0;
            pwm_left    <= 1'b0;
            pwm_right   <= 1'b0;
        end else begin
            if (pwm_div_cnt == PW'(PWM_DIV - 1)) begin
                pwm_div_cnt <= '0;
                pwm_cnt     <= pwm_cnt + 1'b1;
            end else begin
                pwm_div_cnt <= pwm_div_cnt + 1'b1;
            end
            pwm_left  <= (in_left  != 2'b00) && (pwm_cnt < duty);
            pwm_right <= (in_right != 2'b00) && (pwm_cnt < duty);
        end
    end
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with PWM_DIV=1, RAMP_DIV=4,
// RAMP_STEP=4, DEAD_CYCLES=8. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_motor_pwm_driver;
    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic [2:0] direction;
    logic [2:0] speed;
    logic       pwm_left, pwm_right;
    logic [1:0] in_left, in_right;
    logic [7:0] duty;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    motor_pwm_driver #(
        .PWM_DIV(1), .RAMP_DIV(4), .RAMP_STEP(4), .DEAD_CYCLES(8), .LEVEL_SCALE(32)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .direction(direction),
        .speed    (speed),
        .pwm_left (pwm_left),
        .pwm_right(pwm_right),
        .in_left  (in_left),
        .in_right (in_right),
        .duty     (duty),
        .busy     (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic count_pwm(output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLOCK_50);
            if (pwm_left)  hl++;
            if (pwm_right) hr++;
        end
    endtask

    initial begin
        int hl, hr, n00;
        rst_n     = 1'b0;
        direction = 3'b001;
        speed     = 3'd3;
        cycles(3);
        check("rst_duty", duty, 0);
        check("rst_in_left", in_left, 0);
        check("rst_in_right", in_right, 0);
        check("rst_pwm_left", pwm_left, 0);
        check("rst_pwm_right", pwm_right, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

`ifdef MOTOR_SOFT_RAMP_EN
        // Ticks land on cycles 4, 8, ... after release.
        cycles(95);
        check("ramp_up_92", duty, 92);
        cycles(1);
        check("ramp_up_96", duty, 96);
        cycles(4);
        check("ramp_hold_96", duty, 96);
        check("ramp_in_fwd", in_left, 2'b10);
        direction = 3'b011;
        cycles(96);
        check("rev_duty_zero", duty, 0);
        check("rev_busy", busy, 1);
        check("rev_in_still_fwd", in_left, 2'b10);
        cycles(1);
        check("rev_in_last_fwd", in_left, 2'b10);
        n00 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            if (in_left == 2'b00 && in_right == 2'b00) n00++;
        end
        check("rev_dead_cycles", n00, 8);
        cycles(1);
        check("rev_in_left", in_left, 2'b01);
        check("rev_in_right", in_right, 2'b01);
        check("rev_duty_start", duty, 0);
        cycles(2);
        check("rev_duty_first_step", duty, 4);
`else
        cycles(1);
        check("start_duty", duty, 96);
        check("start_in_lag", in_left, 2'b00);
        cycles(1);
        check("start_in_left", in_left, 2'b10);
        check("start_in_right", in_right, 2'b10);
        cycles(1);
        count_pwm(hl, hr);
        check("pwm96_left", hl, 96);
        check("pwm96_right", hr, 96);

        speed = 3'd7;
        cycles(1);
        check("sat_duty", duty, 224);
        speed = 3'd0;
        cycles(1);
        check("zero_duty", duty, 0);
        cycles(1);
        check("zero_in_left", in_left, 2'b10);
        check("zero_busy", busy, 0);

        speed = 3'd2;
        cycles(1);
        check("step_duty_64", duty, 64);
        count_pwm(hl, hr);
        check("pwm64_left", hl, 64);

        // Reversal: one RAMP_DOWN cycle, then eight DEAD cycles.
        direction = 3'b011;
        cycles(1);
        check("rev_duty_drop", duty, 0);
        check("rev_busy_lag", busy, 0);
        cycles(1);
        check("rev_busy", busy, 1);
        check("rev_in_still_fwd", in_left, 2'b10);
        n00 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            if (in_left == 2'b00 && in_right == 2'b00) n00++;
            if (i == 2) direction = 3'b001;
            if (i == 4) direction = 3'b011;
        end
        check("rev_dead_cycles", n00, 8);
        cycles(1);
        check("rev_in_left", in_left, 2'b01);
        check("rev_in_right", in_right, 2'b01);
        check("rev_duty", duty, 64);
        check("rev_busy_clear", busy, 0);

        direction = 3'b010;
        cycles(11);
        check("turn_in_left", in_left, 2'b01);
        check("turn_in_right", in_right, 2'b10);
        count_pwm(hl, hr);
        check("turn_pwm_left", hl, 64);
        check("turn_pwm_right", hr, 64);

        direction = 3'b000;
        cycles(11);
        check("stop_in_left", in_left, 2'b00);
        check("stop_duty", duty, 0);
        check("stop_busy", busy, 0);

        // Abort: direction returns before the dead time starts.
        direction = 3'b001;
        cycles(2);
        check("run_again_duty", duty, 64);
        check("run_again_in", in_left, 2'b10);
        direction = 3'b011;
        cycles(1);
        direction = 3'b001;
        cycles(1);
        check("abort_duty", duty, 64);
        check("abort_in", in_left, 2'b10);
        cycles(1);
        check("abort_busy", busy, 0);
        check("abort_in_hold", in_left, 2'b10);

        #2 rst_n = 1'b0;
        #1;
        check("async_rst_duty", duty, 0);
        check("async_rst_in", in_left, 2'b00);
        check("async_rst_pwm", pwm_left, 0);
        cycles(1);
        rst_n = 1'b1;
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Downstream consumer of the speed FSM's `speed` level and the `direction` state. Converts them into ramped PWM enables and H-bridge direction pins for the left and right drive motors. Duty slews toward a target at a fixed rate. Any change of bridge polarity is preceded by a ramp to zero and a dead-time interval, so the motors are never hard-reversed.

## Interface
- `PWM_DIV`, default 10: `CLOCK_50` cycles per PWM counter step; one PWM period is 256 steps, ≈19.5 kHz.
- `RAMP_DIV`, default 50000: `CLOCK_50` cycles per ramp tick (1 ms).
- `RAMP_STEP`, default 4: duty change per ramp tick.
- `DEAD_CYCLES`, default 5000: cycles held at zero duty before the bridge polarity switches.
- `LEVEL_SCALE`, default 32: duty per speed unit.
- `CLOCK_50` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `direction` in 3: requested motion. 001 forward, 011 reverse, 010 turn left, 100 turn right; any other value means stop.
- `speed` in 3: speed level 0–7.
- `pwm_left`, `pwm_right` out 1: PWM enable per motor.
- `in_left`, `in_right` out 2: bridge pins. 10 = forward, 01 = reverse, 00 = coast.
- `duty` out 8: current applied duty, shared by both motors.
- `busy` out 1: high in states RAMP_DOWN and DEAD.

## Operation
- **Target duty:** `target = min(speed*LEVEL_SCALE, 255)` when `direction` is a move code; `target = 0` otherwise.
- **Per-motor mapping:**
  - 001: both motors forward.
  - 011: both motors reverse.
  - 010: left reverse, right forward.
  - 100: left forward, right reverse.
- **Latched direction:** `active_dir` holds the direction the bridge is currently wired for. `in_*` are driven only from `active_dir`.
- **FSM states:** STOP, RUN, RAMP_DOWN, DEAD.
- **STOP:** duty = 0, `in_*` = 00.
  - Move code seen → latch `active_dir`, go to RUN in the same cycle.
- **RUN:** duty ramps toward `target`.
  - `direction` ≠ `active_dir` (including stop) → RAMP_DOWN.
- **RAMP_DOWN:** duty ramps toward 0.
  - `direction` returns to `active_dir` → back to RUN, with no dead time.
  - duty == 0 → DEAD, load the dead counter with `DEAD_CYCLES`-1, set `in_*` = 00.
- **DEAD:** counter decrements each cycle. At 0, `direction` is sampled:
  - move code → latch it, go to RUN;
  - otherwise → STOP.
  - Direction changes during DEAD are ignored until the counter expires.
- **Ramp:** on each ramp tick, `duty` moves by `RAMP_STEP` toward its goal, clamped so it never overshoots. A target change mid-ramp simply redirects the ramp.
- **PWM:** 8-bit `pwm_cnt` advances once every `PWM_DIV` cycles and wraps 255→0.
  - `pwm_* = (pwm_cnt < duty)` while the bridge is not 00; otherwise 0.
  - duty 0 gives constant low; duty 255 gives high for 255 of every 256 steps.
- **Arithmetic:** `speed*LEVEL_SCALE` is computed at 11 bits, then saturated to 8 bits. All counters are unsigned; the prescaler and ramp counters wrap to 0 on their tick.

## Timing
- **Reset values:** `duty` = 0, `pwm_*` = 0, `in_*` = 00, `busy` = 0, state STOP, `active_dir` = 000, all counters 0.
- **Reset mid-operation:** outputs go low immediately (asynchronous); ramp state is lost.
- **Outputs:** all registered. `in_*` and `busy` follow the state register with 1-cycle latency.
- **`pwm_*`:** updates the cycle after `pwm_cnt` or `duty` changes.
- **Ramp timer:** free-runs from reset; the first tick arrives `RAMP_DIV` cycles after reset release. Direction input is not aligned to ticks.
- **Minimum reversal time:** `ceil(duty/RAMP_STEP)` ramp ticks plus `DEAD_CYCLES` plus 1 cycle.
- **Simultaneous events:**
  - A ramp tick and a state change in the same cycle: the ramp uses the goal of the new state.
  - DEAD expiry and a direction change in the same cycle: the new direction is sampled.

## Configuration
- **Macro:** `MOTOR_SOFT_RAMP_EN`.
- **Defined:** slewed duty as described above.
- **Undefined:** `duty` loads its goal directly on the next cycle. RAMP_DOWN therefore lasts one cycle, and DEAD is still enforced. The ramp timer is removed.

## Test plan
All scenarios use `PWM_DIV`=1, `RAMP_DIV`=4, `RAMP_STEP`=4, `DEAD_CYCLES`=8.
- **Reset check:** hold `rst_n`=0 with `direction`=001, `speed`=3 → all outputs 0. Release reset → `in_*`=10 the next cycle; `duty` reaches 96 after 24 ticks (96 cycles) and holds.
- **Saturation:** `direction`=001, `speed`=7 → target 224. With `speed` then set to 0, `duty` ramps down to 0 while `in_*` stays 10.
- **Reversal:** at `duty`=96, set `direction`=011 → `busy`=1, `duty` reaches 0 after 24 ticks. `in_*`=00 for 8 cycles, then `in_*`=01 and `duty` ramps back to 96.
- **Abort:** at `duty`=64 in RAMP_DOWN, return `direction` to 001 → RUN, `busy`=0, `duty` climbs back with `in_*` never leaving 10.
- **PWM duty:** `duty`=64 with `PWM_DIV`=1 → `pwm_left` high exactly 64 of each 256 cycles. Turn 010 → `in_left`=01, `in_right`=10.
- **Macro off:** with `MOTOR_SOFT_RAMP_EN` undefined, a step to `speed`=2 → `duty`=64 one cycle later. A reversal shows 1 cycle of RAMP_DOWN plus 8 DEAD cycles.
